// File: rtl/ds_dac_ctrl.sv
// Delta-sigma DAC feeder: sample FIFO, tick/strobe divider and play/ramp-down sequencer.
// Samples leave the FIFO on strobes; a stop ramps the output to zero before resetting the modulator.
module ds_dac_ctrl #(
    parameter int DEPTH = 8,
    parameter int STEP  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [15:0]               osr_div,
    input  logic [7:0]                ratio,
    input  logic                      s_valid,
    input  logic signed [15:0]        s_data,
    output logic                      s_ready,
    output logic                      dac_cke,
    output logic signed [15:0]        dac_din,
    output logic                      dac_rst,
    output logic                      busy,
    output logic                      underflow,
    output logic [15:0]               ucnt,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);
    localparam logic signed [16:0] STEP_S = 17'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_STOP} state_t;

    state_t                  r_state, w_next;
    logic [15:0]             r_osr_q, r_div_cnt;
    logic [7:0]              r_ratio_q, r_tick_cnt;
    logic signed [15:0]      r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic signed [15:0]      r_din;
    logic                    r_cke, r_under;
    logic [15:0]             r_ucnt;
    logic                    w_tick, w_strobe, w_push, w_pop, w_under, w_flush, w_ramp, w_latch;

    // Move a sample one STEP toward zero without crossing it.
    function automatic logic signed [15:0] ramp_to_zero(input logic signed [15:0] din);
        logic signed [16:0] v;
        v = 17'(din);
        if (v > STEP_S)
            return 16'(v - STEP_S);
        else if (v < -STEP_S)
            return 16'(v + STEP_S);
        else
            return '0;
    endfunction

    assign w_tick   = (r_state != S_IDLE) && (r_div_cnt == r_osr_q);
    assign w_strobe = w_tick && (r_tick_cnt == r_ratio_q);

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (en) w_next = S_PRIME;
            S_PRIME: begin
                if (!en)
                    w_next = S_STOP;
                else if (w_strobe && r_level >= HALF)
                    w_next = S_RUN;
            end
            S_RUN:   if (!en) w_next = S_STOP;
            S_STOP:  if (w_strobe && r_din == 16'sd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_latch = (r_state == S_IDLE) && en;
        w_pop   = 1'b0;
        w_under = 1'b0;
        w_flush = 1'b0;
        w_ramp  = 1'b0;
        case (r_state)
            S_PRIME: w_pop = w_strobe && en && (r_level >= HALF);
            S_RUN: begin
                w_pop   = w_strobe && (r_level != '0);
                w_under = w_strobe && (r_level == '0);
            end
            S_STOP: begin
                w_flush = w_strobe && (r_din == 16'sd0);
                w_ramp  = w_strobe && (r_din != 16'sd0);
            end
            default: ;
        endcase
    end

    assign w_push = s_valid && s_ready && !w_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_osr_q    <= '0;
            r_ratio_q  <= '0;
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
        end else begin
            if (w_latch) begin
                r_osr_q   <= osr_div;
                r_ratio_q <= ratio;
            end
            if (r_state == S_IDLE || w_flush) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= (r_tick_cnt == r_ratio_q) ? 8'd0 : r_tick_cnt + 8'd1;
            end else begin
                r_div_cnt  <= r_div_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= s_data;
    end

    // Pop and push in one cycle leave the level untouched; a flush wins over both.
    always_ff @(posedge clk) begin
        if (!rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_din   <= '0;
            r_cke   <= 1'b0;
            r_under <= 1'b0;
            r_ucnt  <= '0;
        end else begin
            r_cke   <= w_tick;
            r_under <= w_under;
            if (w_pop)
                r_din <= r_mem[r_rd_ptr];
            else if (w_ramp)
                r_din <= ramp_to_zero(r_din);
            if (w_under && r_ucnt != 16'hFFFF)
                r_ucnt <= r_ucnt + 16'd1;
        end
    end

    assign s_ready   = (r_level < FULL);
    assign level     = r_level;
    assign dac_cke   = r_cke;
    assign dac_din   = r_din;
    assign dac_rst   = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign underflow = r_under;
    assign ucnt      = r_ucnt;
endmodule

// File: tb/tb_ds_dac_ctrl.sv
// Bench for ds_dac_ctrl: directed play/stop rounds then randomized traffic,
// compared every cycle against a queue-based model that derives ticks from elapsed cycles.
module tb_ds_dac_ctrl;
    localparam int DEPTH = 8;
    localparam int STEP  = 4096;
    localparam int NCYC  = 6000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic [15:0]        osr_div = '0;
    logic [7:0]         ratio = '0;
    logic               s_valid = 1'b0;
    logic signed [15:0] s_data = '0;
    logic               s_ready, dac_cke, dac_rst, busy, underflow;
    logic signed [15:0] dac_din;
    logic [15:0]        ucnt;
    logic [$clog2(DEPTH):0] level;

    ds_dac_ctrl #(.DEPTH(DEPTH), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .en(en), .osr_div(osr_div), .ratio(ratio),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .dac_cke(dac_cke), .dac_din(dac_din), .dac_rst(dac_rst),
        .busy(busy), .underflow(underflow), .ucnt(ucnt), .level(level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 prime, 2 run, 3 stop; m_k = cycles spent since leaving idle.
    int m_state = 0, m_k = 0, m_osr = 0, m_ratio = 0, m_din = 0, m_ucnt = 0;
    int m_cke = 0, m_under = 0;
    int q[$];

    task automatic model_step();
        int period, psize;
        bit tick, strobe, push;
        if (!rst) begin
            m_state = 0; m_k = 0; m_osr = 0; m_ratio = 0; m_din = 0;
            m_ucnt = 0; m_cke = 0; m_under = 0; q.delete();
            return;
        end
        psize  = q.size();
        push   = s_valid && (psize < DEPTH);
        period = (m_osr + 1) * (m_ratio + 1);
        tick   = (m_state != 0) && ((m_k % (m_osr + 1)) == m_osr);
        strobe = (m_state != 0) && ((m_k % period) == period - 1);
        m_cke   = tick;
        m_under = 0;
        case (m_state)
            0: if (en) begin
                m_state = 1; m_k = 0; m_osr = osr_div; m_ratio = ratio;
            end
            1: begin
                m_k++;
                if (!en) m_state = 3;
                else if (strobe && psize >= DEPTH / 2) begin
                    m_din = q.pop_front(); m_state = 2;
                end
            end
            2: begin
                m_k++;
                if (strobe) begin
                    if (psize > 0) m_din = q.pop_front();
                    else begin
                        m_under = 1;
                        if (m_ucnt < 65535) m_ucnt++;
                    end
                end
                if (!en) m_state = 3;
            end
            default: begin
                m_k++;
                if (strobe) begin
                    if (m_din == 0) begin
                        m_state = 0; m_k = 0; q.delete(); push = 0;
                    end else if (m_din > STEP) m_din -= STEP;
                    else if (m_din < -STEP) m_din += STEP;
                    else m_din = 0;
                end
            end
        endcase
        if (push) q.push_back(int'(s_data));
    endtask

    task automatic check_all();
        chk("level", int'(level), q.size());
        chk("s_ready", int'(s_ready), int'(q.size() < DEPTH));
        chk("busy", int'(busy), int'(m_state != 0));
        chk("dac_rst", int'(dac_rst), int'(m_state == 0));
        chk("dac_cke", int'(dac_cke), m_cke);
        chk("dac_din", int'(dac_din), m_din);
        chk("underflow", int'(underflow), m_under);
        chk("ucnt", int'(ucnt), m_ucnt);
    endtask

    function automatic int dir_word(input int r, input int i);
        int tbl0 [8] = '{10000, -5000, 123, -32768, 32767, 0, 7, -1};
        int tbl1 [8] = '{-5000, 10000, 4096, -4096, 4097, -4097, 1, 2};
        return (r == 0) ? tbl0[i] : tbl1[i];
    endfunction

    int en_hold = 0;
    int fill_pct = 50;

    task automatic drive(input int cyc);
        int r, b;
        if (cyc < 200) begin
            r = cyc / 100;
            b = cyc % 100;
            rst     = (b >= 2);
            osr_div = (b > 20) ? 16'($urandom) : 16'd3;
            ratio   = (b > 20) ? 8'($urandom) : 8'd1;
            s_valid = (b >= 3 && b < 11);
            s_data  = (b >= 3 && b < 11) ? 16'(dir_word(r, b - 3)) : 16'sd0;
            en      = (b >= 14 && b < 28);
        end else begin
            if (cyc % 500 == 0) fill_pct = $urandom_range(10, 95);
            if ($urandom_range(0, 59) == 0) en_hold = !en_hold;
            rst     = ($urandom_range(0, 399) != 0);
            en      = en_hold[0];
            osr_div = 16'($urandom_range(0, 3));
            ratio   = 8'($urandom_range(0, 3));
            s_valid = ($urandom_range(0, 99) < fill_pct);
            s_data  = 16'($urandom);
        end
    endtask

    initial begin
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc > 0) check_all();
            drive(cyc);
            model_step();
        end
        @(negedge clk);
        check_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
